single_stream_loader: RTL and testbench

SINGLE_STREAM_LOADER -- requirements
Module: single_stream_loader

---
 rtl/conv_pkg.sv | 19 +
 rtl/single_stream_loader_if.sv | 23 ++
 rtl/single_stream_loader.sv | 164 ++++++++++++++++
 tb/tb_single_stream_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and sizes for the single-stream conv loader.
// Holds the loader FSM state encoding and the tile/filter/result element counts.
// Pure declarations; no logic.
package conv_pkg;

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    KICK   = 3'd2,
    RUN    = 3'd3,
    DRAIN  = 3'd4
  } state_e;

  localparam int N_A             = 16; // 4x4 activation tile
  localparam int N_B             = 9;  // 3x3 filter
  localparam int N_C             = 4;  // 2x2 result
  localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/single_stream_loader_if.sv
// Byte-stream handshake bundle: upstream load bytes in, result bytes out.
// Ports: in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data (downstream).
// slave = loader view, master = producer/consumer view.
interface single_stream_loader_if;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/single_stream_loader.sv
// Purpose: loads a 4x4 activation tile and 3x3 filter from one byte stream, kicks the
//          engine, waits for done (or timeout) and streams the four 2x2 results out.
// Latency: 25 load beats, 1 KICK cycle, engine run time, then 4 result beats.
// Backpressure: in_valid low stalls loading; out_ready low holds the current result byte.
// Ports: clk, rst (sync, active-high); s (stream handshakes); a11..a44, b11..b33,
//        eng_rst, active_single to the engine; done_single, c11..c22 from it; err sticky.
module single_stream_loader
  import conv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  single_stream_loader_if.slave s,
  output logic [7:0] a11, a12, a13, a14,
  output logic [7:0] a21, a22, a23, a24,
  output logic [7:0] a31, a32, a33, a34,
  output logic [7:0] a41, a42, a43, a44,
  output logic [7:0] b11, b12, b13,
  output logic [7:0] b21, b22, b23,
  output logic [7:0] b31, b32, b33,
  output logic       eng_rst,
  output logic       active_single,
  input  logic       done_single,
  input  logic [7:0] c11, c12, c21, c22,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e        state_q;
  logic [3:0]    load_cnt_q;
  logic [1:0]    drain_idx_q;
  logic [TW-1:0] tmo_cnt_q;
  logic [7:0]    a_q   [N_A];
  logic [7:0]    b_q   [N_B];
  logic [7:0]    res_q [N_C];
  logic          done_q;
  logic          err_q;
  logic          eng_rst_q;
  logic          active_q;
  logic          out_valid_q;
  logic [7:0]    out_data_q;

  logic in_fire;
  logic out_fire;
  logic done_rise;
  logic tmo_hit;

  // in_ready is combinational so that no beat can be taken in a reset cycle.
  assign s.in_ready = ~rst & ((state_q == LOAD_A) | (state_q == LOAD_B));
  assign in_fire    = s.in_valid & s.in_ready;
  assign out_fire   = out_valid_q & s.out_ready;
  // A done level left over from an earlier run never looks like a new completion.
  assign done_rise  = done_single & ~done_q;
  assign tmo_hit    = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD_A;
      load_cnt_q  <= '0;
      drain_idx_q <= '0;
      tmo_cnt_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      eng_rst_q   <= 1'b0;
      active_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      for (int i = 0; i < N_A; i++) a_q[i] <= 8'h00;
      for (int i = 0; i < N_B; i++) b_q[i] <= 8'h00;
      for (int i = 0; i < N_C; i++) res_q[i] <= 8'h00;
    end else begin
      done_q    <= done_single;
      eng_rst_q <= 1'b0;
      case (state_q)
        LOAD_A: begin
          if (in_fire) begin
            // Row-major beat order maps straight onto the flat tile index.
            a_q[load_cnt_q] <= s.in_data;
            if (load_cnt_q == 4'(N_A - 1)) begin
              load_cnt_q <= '0;
              state_q    <= LOAD_B;
            end else begin
              load_cnt_q <= load_cnt_q + 4'd1;
            end
          end
        end
        LOAD_B: begin
          if (in_fire) begin
            b_q[load_cnt_q] <= s.in_data;
            if (load_cnt_q == 4'(N_B - 1)) begin
              load_cnt_q <= '0;
              eng_rst_q  <= 1'b1;
              state_q    <= KICK;
            end else begin
              load_cnt_q <= load_cnt_q + 4'd1;
            end
          end
        end
        KICK: begin
          active_q  <= 1'b1;
          tmo_cnt_q <= '0;
          state_q   <= RUN;
        end
        RUN: begin
          // Completion is checked first so it wins over a same-cycle timeout.
          if (done_rise) begin
            res_q[0]    <= c11;
            res_q[1]    <= c12;
            res_q[2]    <= c21;
            res_q[3]    <= c22;
            out_data_q  <= c11;
            out_valid_q <= 1'b1;
            active_q    <= 1'b0;
            drain_idx_q <= '0;
            state_q     <= DRAIN;
          end else if (tmo_hit) begin
            for (int i = 0; i < N_C; i++) res_q[i] <= 8'h00;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b1;
            active_q    <= 1'b0;
            err_q       <= 1'b1;
            drain_idx_q <= '0;
            state_q     <= DRAIN;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (drain_idx_q == 2'(N_C - 1)) begin
              out_valid_q <= 1'b0;
              out_data_q  <= 8'h00;
              drain_idx_q <= '0;
              tmo_cnt_q   <= '0;
              state_q     <= LOAD_A;
            end else begin
              drain_idx_q <= drain_idx_q + 2'd1;
              out_data_q  <= res_q[drain_idx_q + 2'd1];
            end
          end
        end
        default: state_q <= LOAD_A;
      endcase
    end
  end

  assign s.out_valid    = out_valid_q;
  assign s.out_data     = out_data_q;
  assign eng_rst        = eng_rst_q;
  assign active_single  = active_q;
  assign err            = err_q;

  assign a11 = a_q[0];  assign a12 = a_q[1];  assign a13 = a_q[2];  assign a14 = a_q[3];
  assign a21 = a_q[4];  assign a22 = a_q[5];  assign a23 = a_q[6];  assign a24 = a_q[7];
  assign a31 = a_q[8];  assign a32 = a_q[9];  assign a33 = a_q[10]; assign a34 = a_q[11];
  assign a41 = a_q[12]; assign a42 = a_q[13]; assign a43 = a_q[14]; assign a44 = a_q[15];

  assign b11 = b_q[0]; assign b12 = b_q[1]; assign b13 = b_q[2];
  assign b21 = b_q[3]; assign b22 = b_q[4]; assign b23 = b_q[5];
  assign b31 = b_q[6]; assign b32 = b_q[7]; assign b33 = b_q[8];

endmodule

// File: tb/tb_single_stream_loader.sv
// Bench for single_stream_loader: directed load/run/drain scenarios with a result scoreboard.
// Stimulus pushes expected result bytes; a negedge monitor pops on every out handshake.
// Engine behaviour (done_single, c values) is driven directly by the stimulus.
module tb_single_stream_loader;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  single_stream_loader_if bus();

  logic [7:0] a11, a12, a13, a14, a21, a22, a23, a24;
  logic [7:0] a31, a32, a33, a34, a41, a42, a43, a44;
  logic [7:0] b11, b12, b13, b21, b22, b23, b31, b32, b33;
  logic       eng_rst, active_single, done_single, err;
  logic [7:0] c11, c12, c21, c22;

  single_stream_loader #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .s(bus),
    .a11(a11), .a12(a12), .a13(a13), .a14(a14),
    .a21(a21), .a22(a22), .a23(a23), .a24(a24),
    .a31(a31), .a32(a32), .a33(a33), .a34(a34),
    .a41(a41), .a42(a42), .a43(a43), .a44(a44),
    .b11(b11), .b12(b12), .b13(b13),
    .b21(b21), .b22(b22), .b23(b23),
    .b31(b31), .b32(b32), .b33(b33),
    .eng_rst(eng_rst), .active_single(active_single), .done_single(done_single),
    .c11(c11), .c12(c12), .c21(c21), .c22(c22),
    .err(err)
  );

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_data_extra: got 0x%02h expected no byte", bus.out_data);
      end else begin
        chk8("out_data", bus.out_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 25 beats: a = a_base+k, b = b_base+b_step*k; optional idle cycle after every third beat.
  task automatic load(input logic [7:0] a_base, input logic [7:0] b_base,
                      input int b_step, input bit stall);
    for (int k = 0; k < 25; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = (k < 16) ? 8'(a_base + 8'(k)) : 8'(b_base + 8'(b_step * (k - 16)));
      @(negedge clk);
      chk1("in_ready_load", bus.in_ready, 1'b1);
      tick();
      if (stall && (k % 3 == 2) && k != 24) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hFF;
        tick();
      end
    end
    bus.in_valid = 1'b0;
  endtask

  // Checks the KICK cycle then the first RUN cycle; returns at the RUN-1 negedge.
  task automatic kick_check();
    @(negedge clk);
    chk1("eng_rst_kick", eng_rst, 1'b1);
    chk1("active_kick", active_single, 1'b0);
    tick();
    @(negedge clk);
    chk1("eng_rst_run", eng_rst, 1'b0);
    chk1("active_run", active_single, 1'b1);
  endtask

  task automatic push_res(input logic [7:0] r0, input logic [7:0] r1,
                          input logic [7:0] r2, input logic [7:0] r3);
    exp_q.push_back(r0);
    exp_q.push_back(r1);
    exp_q.push_back(r2);
    exp_q.push_back(r3);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
    chk1("drain_empty", exp_q.size() == 0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b1;
    done_single = 1'b0; c11 = 8'h00; c12 = 8'h00; c21 = 8'h00; c22 = 8'h00;

    // Reset state
    tick(); tick();
    @(negedge clk);
    chk1("rst_in_ready", bus.in_ready, 1'b0);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk8("rst_out_data", bus.out_data, 8'h00);
    chk8("rst_a11", a11, 8'h00);
    chk8("rst_b33", b33, 8'h00);
    chk1("rst_err", err, 1'b0);
    chk1("rst_eng_rst", eng_rst, 1'b0);
    chk1("rst_active", active_single, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk1("idle_in_ready", bus.in_ready, 1'b1);
    tick();

    // Continuous load 1..16 / 0x01, kick timing, done after 38 RUN cycles
    load(8'h01, 8'h01, 0, 1'b0);
    kick_check();
    chk8("t1_a11", a11, 8'h01);
    chk8("t1_a14", a14, 8'h04);
    chk8("t1_a23", a23, 8'h07);
    chk8("t1_a44", a44, 8'h10);
    chk8("t1_b11", b11, 8'h01);
    chk8("t1_b33", b33, 8'h01);
    for (int i = 0; i < 37; i++) tick();
    c11 = 8'h2D; c12 = 8'h36; c21 = 8'h51; c22 = 8'h5A;
    push_res(8'h2D, 8'h36, 8'h51, 8'h5A);
    done_single = 1'b1;
    @(negedge clk);
    chk1("t1_active_last", active_single, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk1("t1_out_valid_run", bus.out_valid, 1'b1);
      chk1("t1_active_drain", active_single, 1'b0);
    end
    tick();
    @(negedge clk);
    chk1("t1_out_valid_end", bus.out_valid, 1'b0);
    chk1("t1_in_ready_end", bus.in_ready, 1'b1);
    chk1("t1_queue_empty", exp_q.size() == 0, 1'b1);
    tick();

    // Stalled load; stale done level ignored; output stall on result 1
    load(8'h10, 8'h80, 1, 1'b1);
    kick_check();
    chk8("t2_a11", a11, 8'h10);
    chk8("t2_a32", a32, 8'h19);
    chk8("t2_a44", a44, 8'h1F);
    chk8("t2_b11", b11, 8'h80);
    chk8("t2_b33", b33, 8'h88);
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      chk1("t2_no_capture_on_level", bus.out_valid, 1'b0);
    end
    tick();
    done_single = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk1("t2_still_running", active_single, 1'b1);
    tick();
    push_res(8'h2D, 8'h36, 8'h51, 8'h5A);
    done_single = 1'b1;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        if (bus.out_valid) seen = 1'b1;
      end
      chk1("t2_out_valid_seen", seen, 1'b1);
    end
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk8("t2_hold_data", bus.out_data, 8'h36);
      chk1("t2_hold_valid", bus.out_valid, 1'b1);
      tick();
    end
    bus.out_ready = 1'b1;
    wait_drain();
    done_single = 1'b0;

    // Timeout: done never rises; in_valid during RUN is ignored
    push_res(8'h00, 8'h00, 8'h00, 8'h00);
    load(8'h40, 8'h01, 0, 1'b0);
    kick_check();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    chk1("t3_in_ready_run", bus.in_ready, 1'b0);
    for (int i = 0; i < 63; i++) tick();
    @(negedge clk);
    chk1("t3_active_run64", active_single, 1'b1);
    chk1("t3_err_run64", err, 1'b0);
    tick();
    @(negedge clk);
    chk1("t3_err_set", err, 1'b1);
    chk1("t3_out_valid", bus.out_valid, 1'b1);
    chk1("t3_active_off", active_single, 1'b0);
    chk1("t3_in_ready_drain", bus.in_ready, 1'b0);
    bus.in_valid = 1'b0;
    wait_drain();
    chk8("t3_a11_kept", a11, 8'h40);
    chk1("t3_err_sticky", err, 1'b1);

    // Reset at load beat 7, then a fresh load starts at a11
    for (int k = 0; k < 7; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(8'h60 + 8'(k));
      tick();
    end
    bus.in_data = 8'h67;
    rst = 1'b1;
    @(negedge clk);
    chk1("t4_in_ready_rst", bus.in_ready, 1'b0);
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk8("t4_a11_clr", a11, 8'h00);
    chk8("t4_a13_clr", a13, 8'h00);
    chk8("t4_a24_clr", a24, 8'h00);
    chk1("t4_err_clr", err, 1'b0);
    chk1("t4_in_ready", bus.in_ready, 1'b1);
    tick();
    load(8'hA0, 8'h03, 1, 1'b0);
    kick_check();
    chk8("t4_a11", a11, 8'hA0);
    chk8("t4_a22", a22, 8'hA5);
    chk8("t4_a44", a44, 8'hAF);
    chk8("t4_b23", b23, 8'h08);
    chk8("t4_b33", b33, 8'h0B);
    tick(); tick(); tick();
    c11 = 8'h01; c12 = 8'h02; c21 = 8'h03; c22 = 8'h04;
    push_res(8'h01, 8'h02, 8'h03, 8'h04);
    done_single = 1'b1;
    wait_drain();
    done_single = 1'b0;
    @(negedge clk);
    chk1("t4_back_to_load", bus.in_ready, 1'b1);
    chk1("t4_err_clean", err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
